// File: rtl/aes_encrypt_sequencer.sv
// aes_encrypt_sequencer
// Control sequencer for AES-128 encryption. Latches a plaintext and walks the
// cipher round order. Each step drives one shared transform unit through an
// enable/ready handshake and captures that unit's result.
//
// Ports:
//   Clk, Rst             clock (rising edge), synchronous active-low reset
//   En                   start/hold request (sampled in IDLE and DONE only)
//   PT / CT              plaintext in (sampled at start) / ciphertext register
//   Ry                   done flag (high in DONE)
//   SelKey               round key index 0..10, equals the current round
//   AddEn..MixEn         stage enables, at most one high, only in WAIT
//   AddRy..MixRy         stage readies, only the active stage's ready is used
//   Text / ModifiedText  state presented to the units / result returned
//   Err                  watchdog error (only with AES_ENC_TIMEOUT_EN)
//
// Optional feature macro: AES_ENC_TIMEOUT_EN adds a stage-ready watchdog of
// TIMEOUT_CYCLES WAIT cycles, an ERR state and the Err port.
module aes_encrypt_sequencer #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic         Clk,
   input  logic         Rst,
   input  logic         En,
   input  logic [127:0] PT,
   output logic [127:0] CT,
   output logic         Ry,
`ifdef AES_ENC_TIMEOUT_EN
   output logic         Err,
`endif
   output logic [3:0]   SelKey,
   output logic         AddEn,
   output logic         SubEn,
   output logic         ShiftEn,
   output logic         MixEn,
   input  logic         AddRy,
   input  logic         SubRy,
   input  logic         ShiftRy,
   input  logic         MixRy,
   output logic [127:0] Text,
   input  logic [127:0] ModifiedText
);

   localparam logic [3:0] LastRound = 4'd10;

   typedef enum logic [2:0] {
      StIdle,
      StWait,
      StStep,
`ifdef AES_ENC_TIMEOUT_EN
      StErr,
`endif
      StDone
   } seqState_e;

   typedef enum logic [1:0] {
      StgAdd,
      StgSub,
      StgShift,
      StgMix
   } stage_e;

   if (TIMEOUT_CYCLES == 0) begin : gBadTimeout
      $error("TIMEOUT_CYCLES must be nonzero");
   end

   seqState_e    stateQ, stateD;
   stage_e       stageQ, stageD;
   logic [3:0]   roundQ, roundD;
   logic [127:0] dataQ, dataD;
   logic [127:0] ctQ, ctD;
   logic         stageRy;

`ifdef AES_ENC_TIMEOUT_EN
   localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
   logic [CntW-1:0] waitCntQ, waitCntD;
`endif

   always_ff @(posedge Clk) begin
      if (!Rst) begin
         stateQ   <= StIdle;
         stageQ   <= StgAdd;
         roundQ   <= '0;
         dataQ    <= '0;
         ctQ      <= '0;
`ifdef AES_ENC_TIMEOUT_EN
         waitCntQ <= '0;
`endif
      end else begin
         stateQ   <= stateD;
         stageQ   <= stageD;
         roundQ   <= roundD;
         dataQ    <= dataD;
         ctQ      <= ctD;
`ifdef AES_ENC_TIMEOUT_EN
         waitCntQ <= waitCntD;
`endif
      end
   end

   // Only the ready of the stage being waited on is honoured.
   always_comb begin
      stageRy = 1'b0;
      unique case (stageQ)
         StgAdd:   stageRy = AddRy;
         StgSub:   stageRy = SubRy;
         StgShift: stageRy = ShiftRy;
         StgMix:   stageRy = MixRy;
      endcase
   end

   always_comb begin
      stateD   = stateQ;
      stageD   = stageQ;
      roundD   = roundQ;
      dataD    = dataQ;
      ctD      = ctQ;
`ifdef AES_ENC_TIMEOUT_EN
      // Counts WAIT cycles; any other state leaves it cleared for the next entry.
      waitCntD = (stateQ == StWait) ? waitCntQ + CntW'(1) : '0;
`endif
      case (stateQ)
         StIdle: begin
            if (En) begin
               dataD  = PT;
               roundD = '0;
               stageD = StgAdd;
               stateD = StWait;
            end
         end
         StWait: begin
            if (stageRy) begin
               dataD  = ModifiedText;
               stateD = StStep;
`ifdef AES_ENC_TIMEOUT_EN
            end else if (waitCntQ == CntW'(TIMEOUT_CYCLES - 1)) begin
               stateD = StErr;
`endif
            end
         end
         StStep: begin
            stateD = StWait;
            unique case (stageQ)
               StgAdd: begin
                  if (roundQ == LastRound) begin
                     stateD = StDone;
                     ctD    = dataQ;
                  end else begin
                     // SelKey moves only here, on entry to a round's first stage.
                     roundD = roundQ + 4'd1;
                     stageD = StgSub;
                  end
               end
               StgSub:   stageD = StgShift;
               // The final round skips MixColumns.
               StgShift: stageD = (roundQ == LastRound) ? StgAdd : StgMix;
               StgMix:   stageD = StgAdd;
            endcase
         end
         StDone: begin
            if (!En) stateD = StIdle;
         end
`ifdef AES_ENC_TIMEOUT_EN
         StErr: begin
            if (!En) stateD = StIdle;
         end
`endif
         default: stateD = StIdle;
      endcase
   end

   always_comb begin
      AddEn   = (stateQ == StWait) && (stageQ == StgAdd);
      SubEn   = (stateQ == StWait) && (stageQ == StgSub);
      ShiftEn = (stateQ == StWait) && (stageQ == StgShift);
      MixEn   = (stateQ == StWait) && (stageQ == StgMix);
      Text    = (stateQ == StWait) ? dataQ : '0;
      Ry      = (stateQ == StDone);
      CT      = ctQ;
      SelKey  = roundQ;
   end

`ifdef AES_ENC_TIMEOUT_EN
   assign Err = (stateQ == StErr);
`endif

endmodule

// File: tb/tb_aes_encrypt_sequencer.sv
// Testbench for aes_encrypt_sequencer: behavioural AES transform units answer
// the stage handshakes; directed runs check ciphertext, latency and stage order.
`timescale 1ns/1ps
module tb_aes_encrypt_sequencer;

   localparam logic [127:0] KeyA = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] PtA  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] CtA  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] KeyB = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] PtB  = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] CtB  = 128'h3925841d02dc09fbdc118597196a0b32;

   logic         Clk = 1'b0;
   logic         Rst = 1'b0;
   logic         En = 1'b0;
   logic [127:0] PT = '0;
   logic [127:0] CT, Text, ModifiedText;
   logic         Ry, AddEn, SubEn, ShiftEn, MixEn;
   logic         AddRy, SubRy, ShiftRy, MixRy;
   logic [3:0]   SelKey;
   logic [3:0]   enVec;
`ifdef AES_ENC_TIMEOUT_EN
   logic         Err;
`endif

   int errors = 0;
   int checks = 0;

   // Transform-unit model controls.
   int   readyDelay = 0;
   int   holdCnt = 0;
   logic stallShift = 1'b0;
   logic spuriousMix = 1'b0;
   logic [7:0]   sboxTab [0:255];
   logic [127:0] rk [0:15];

   // Enable-pulse log.
   int           pulseCnt = 0;
   int           multiViol = 0;
   int           gapViol = 0;
   int           textViol = 0;
   int           pulseStage [0:1023];
   int           pulseKey [0:1023];
   logic [3:0]   prevEn = '0;
   logic [127:0] pulseText = '0;
   int           runBase, multiBase, gapBase, textBase;

`ifdef AES_ENC_TIMEOUT_EN
   aes_encrypt_sequencer #(.TIMEOUT_CYCLES(16)) dut (
`else
   aes_encrypt_sequencer dut (
`endif
      .Clk(Clk), .Rst(Rst), .En(En), .PT(PT), .CT(CT), .Ry(Ry),
`ifdef AES_ENC_TIMEOUT_EN
      .Err(Err),
`endif
      .SelKey(SelKey), .AddEn(AddEn), .SubEn(SubEn), .ShiftEn(ShiftEn), .MixEn(MixEn),
      .AddRy(AddRy), .SubRy(SubRy), .ShiftRy(ShiftRy), .MixRy(MixRy),
      .Text(Text), .ModifiedText(ModifiedText)
   );

   always #5 Clk = ~Clk;

   assign enVec = {MixEn, ShiftEn, SubEn, AddEn};

   // ---------------- AES reference pieces ----------------
   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xtime(x);
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
      logic [15:0] t;
      t = {b, b} << n;
      return t[15:8];
   endfunction

   task automatic buildSbox();
      logic [7:0] inv;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h01;
         if (x == 0) inv = 8'h00;
         else for (int i = 0; i < 254; i++) inv = gmul(inv, 8'(x));
         sboxTab[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4)
                      ^ 8'h63;
      end
   endtask

   function automatic logic [127:0] subBytes(input logic [127:0] s);
      logic [127:0] o;
      for (int i = 0; i < 16; i++) o[127-8*i -: 8] = sboxTab[s[127-8*i -: 8]];
      return o;
   endfunction

   function automatic logic [127:0] shiftRows(input logic [127:0] s);
      logic [127:0] o;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
      return o;
   endfunction

   function automatic logic [127:0] mixColumns(input logic [127:0] s);
      logic [127:0] o;
      logic [7:0] a0, a1, a2, a3;
      for (int c = 0; c < 4; c++) begin
         a0 = s[127-32*c -: 8];
         a1 = s[119-32*c -: 8];
         a2 = s[111-32*c -: 8];
         a3 = s[103-32*c -: 8];
         o[127-32*c -: 8] = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
         o[119-32*c -: 8] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
         o[111-32*c -: 8] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
         o[103-32*c -: 8] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
      end
      return o;
   endfunction

   task automatic setKey(input logic [127:0] key);
      logic [31:0] w [0:43];
      logic [31:0] t;
      logic [7:0]  rcon;
      rcon = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t = {t[23:0], t[31:24]};
            t = {sboxTab[t[31:24]], sboxTab[t[23:16]], sboxTab[t[15:8]], sboxTab[t[7:0]]};
            t = t ^ {rcon, 24'h0};
            rcon = xtime(rcon);
         end
         w[i] = w[i-4] ^ t;
      end
      for (int r = 0; r < 16; r++) rk[r] = '0;
      for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
   endtask

   // ---------------- transform units ----------------
   always_comb begin
      ModifiedText = '0;
      if (AddEn)        ModifiedText = Text ^ rk[SelKey];
      else if (SubEn)   ModifiedText = subBytes(Text);
      else if (ShiftEn) ModifiedText = shiftRows(Text);
      else if (MixEn)   ModifiedText = mixColumns(Text);
   end

   always @(posedge Clk) holdCnt <= (enVec != 4'd0) ? holdCnt + 1 : 0;

   assign AddRy   = AddEn && (holdCnt >= readyDelay);
   assign SubRy   = SubEn && (holdCnt >= readyDelay);
   assign ShiftRy = ShiftEn && (holdCnt >= readyDelay) && !stallShift;
   assign MixRy   = (MixEn && (holdCnt >= readyDelay)) || spuriousMix;

   // ---------------- enable monitor ----------------
   function automatic int stageCode(input logic [3:0] v);
      case (v)
         4'b0001: return 0;
         4'b0010: return 1;
         4'b0100: return 2;
         4'b1000: return 3;
         default: return 7;
      endcase
   endfunction

   always @(negedge Clk) begin
      if ($countones(enVec) > 1) multiViol <= multiViol + 1;
      if (enVec != 4'd0 && prevEn != 4'd0 && enVec != prevEn) gapViol <= gapViol + 1;
      if (enVec != 4'd0 && prevEn == 4'd0) begin
         if (pulseCnt < 1024) begin
            pulseStage[pulseCnt] <= stageCode(enVec);
            pulseKey[pulseCnt]   <= int'(SelKey);
         end
         pulseCnt  <= pulseCnt + 1;
         pulseText <= Text;
      end else if (enVec != 4'd0 && Text != pulseText) begin
         textViol <= textViol + 1;
      end
      prevEn <= enVec;
   end

   // ---------------- run helpers (no comparisons) ----------------
   task automatic startRun(input logic [127:0] pt);
      @(negedge Clk);
      PT = pt;
      En = 1'b1;
   endtask

   // Edges are counted from and including the start edge.
   task automatic waitRy(input int budget, output int edges, output bit seen);
      edges = 0;
      seen = 1'b0;
      while (!seen && edges < budget) begin
         @(posedge Clk);
         edges++;
         #1;
         if (Ry) seen = 1'b1;
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      Rst = 1'b0;
      En = 1'b0;
      repeat (3) @(posedge Clk);
      #1;
      checks++; if (CT !== 128'h0) begin errors++; $display("FAIL reset_ct: got %h want 0", CT); end
      checks++; if (Ry !== 1'b0) begin errors++; $display("FAIL reset_ry: got %b want 0", Ry); end
      checks++; if (SelKey !== 4'd0) begin errors++; $display("FAIL reset_selkey: got %0d want 0", SelKey); end
      checks++; if (enVec !== 4'd0) begin errors++; $display("FAIL reset_en: got %b want 0000", enVec); end
      checks++; if (Text !== 128'h0) begin errors++; $display("FAIL reset_text: got %h want 0", Text); end
`ifdef AES_ENC_TIMEOUT_EN
      checks++; if (Err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", Err); end
`endif
      @(negedge Clk);
      Rst = 1'b1;
   endtask

   task automatic test_known_answer();
      int edges;
      bit seen;
      setKey(KeyA);
      readyDelay = 0;
      @(negedge Clk);
      runBase = pulseCnt; multiBase = multiViol; gapBase = gapViol; textBase = textViol;
      startRun(PtA);
      waitRy(400, edges, seen);
      checks++; if (!seen) begin errors++; $display("FAIL kat_done: Ry never rose within 400 edges"); end
      checks++; if (edges !== 81) begin errors++; $display("FAIL kat_latency: got %0d edges want 81", edges); end
      checks++; if (CT !== CtA) begin errors++; $display("FAIL kat_ct: got %h want %h", CT, CtA); end
      @(posedge Clk); #1;
      checks++; if (Ry !== 1'b1) begin errors++; $display("FAIL kat_hold: Ry got %b want 1 while En high", Ry); end
      @(negedge Clk);
      En = 1'b0;
      @(posedge Clk); #1;
      checks++; if (Ry !== 1'b0) begin errors++; $display("FAIL kat_release: Ry got %b want 0", Ry); end
   endtask

   task automatic test_sequence();
      int n;
      n = pulseCnt - runBase;
      checks++; if (n !== 40) begin errors++; $display("FAIL seq_count: got %0d pulses want 40", n); end
      for (int k = 0; k < 40; k++) begin
         int expStage;
         int expKey;
         if (k == 0) begin
            expStage = 0; expKey = 0;
         end else if (k <= 36) begin
            expKey = (k - 1) / 4 + 1;
            expStage = ((k - 1) % 4 + 1) % 4;
         end else begin
            expKey = 10;
            expStage = (k == 37) ? 1 : (k == 38) ? 2 : 0;
         end
         if (runBase + k < 1024) begin
            checks++;
            if (pulseStage[runBase+k] !== expStage || pulseKey[runBase+k] !== expKey) begin
               errors++;
               $display("FAIL seq_pulse%0d: got stage %0d key %0d want stage %0d key %0d", k,
                        pulseStage[runBase+k], pulseKey[runBase+k], expStage, expKey);
            end
         end
      end
      checks++; if (multiViol - multiBase !== 0) begin errors++; $display("FAIL seq_onehot: got %0d multi-enable cycles want 0", multiViol - multiBase); end
      checks++; if (gapViol - gapBase !== 0) begin errors++; $display("FAIL seq_gap: got %0d gapless changes want 0", gapViol - gapBase); end
      checks++; if (textViol - textBase !== 0) begin errors++; $display("FAIL seq_text: got %0d Text changes want 0", textViol - textBase); end
   endtask

   task automatic test_stretched();
      int edges;
      bit seen;
      setKey(KeyB);
      readyDelay = 3;
      textBase = textViol;
      startRun(PtB);
      waitRy(600, edges, seen);
      checks++; if (edges !== 201) begin errors++; $display("FAIL stretch_latency: got %0d edges want 201", edges); end
      checks++; if (CT !== CtB) begin errors++; $display("FAIL stretch_ct: got %h want %h", CT, CtB); end
      checks++; if (textViol - textBase !== 0) begin errors++; $display("FAIL stretch_text: got %0d Text changes want 0", textViol - textBase); end
      @(negedge Clk);
      En = 1'b0;
      @(posedge Clk);
   endtask

   task automatic test_spurious();
      int edges;
      int n;
      bit seen;
      logic [127:0] txt;
      setKey(KeyA);
      readyDelay = 3;
      startRun(PtA);
      n = 0;
      do begin @(negedge Clk); n++; end while (!SubEn && n < 20);
      checks++; if (SubEn !== 1'b1) begin errors++; $display("FAIL spur_find: SubEn got %b want 1", SubEn); end
      txt = Text;
      spuriousMix = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(negedge Clk);
         checks++;
         if (SubEn !== 1'b1 || MixEn !== 1'b0 || Text !== txt) begin
            errors++;
            $display("FAIL spur_hold%0d: got sub=%b mix=%b text=%h want sub=1 mix=0 text=%h", i,
                     SubEn, MixEn, Text, txt);
         end
      end
      spuriousMix = 1'b0;
      En = 1'b0;
      waitRy(600, edges, seen);
      checks++; if (!seen) begin errors++; $display("FAIL spur_done: Ry never rose within 600 edges"); end
      checks++; if (CT !== CtA) begin errors++; $display("FAIL spur_ct: got %h want %h", CT, CtA); end
      @(posedge Clk); #1;
      checks++; if (Ry !== 1'b0) begin errors++; $display("FAIL spur_idle: Ry got %b want 0", Ry); end
   endtask

   task automatic test_reset_midrun();
      int edges;
      int n;
      bit seen;
      setKey(KeyA);
      readyDelay = 0;
      startRun(PtA);
      n = 0;
      do begin @(negedge Clk); n++; end while (!(SelKey == 4'd5 && enVec != 4'd0) && n < 200);
      checks++; if (SelKey !== 4'd5) begin errors++; $display("FAIL mid_find: SelKey got %0d want 5", SelKey); end
      Rst = 1'b0;
      En = 1'b0;
      @(posedge Clk); #1;
      checks++;
      if (CT !== 128'h0 || Ry !== 1'b0 || SelKey !== 4'd0 || enVec !== 4'd0 || Text !== 128'h0) begin
         errors++;
         $display("FAIL mid_reset: got ct=%h ry=%b key=%0d en=%b text=%h want all 0", CT, Ry,
                  SelKey, enVec, Text);
      end
      @(negedge Clk);
      Rst = 1'b1;
      @(posedge Clk); #1;
      checks++; if (enVec !== 4'd0 || Text !== 128'h0) begin errors++; $display("FAIL mid_idle: got en=%b text=%h want 0", enVec, Text); end
      startRun(PtA);
      waitRy(400, edges, seen);
      checks++; if (edges !== 81) begin errors++; $display("FAIL mid_latency: got %0d edges want 81", edges); end
      checks++; if (CT !== CtA) begin errors++; $display("FAIL mid_ct: got %h want %h", CT, CtA); end
      @(negedge Clk);
      En = 1'b0;
      @(posedge Clk);
   endtask

   task automatic test_back_to_back();
      int edges;
      bit seen;
      setKey(KeyB);
      readyDelay = 0;
      startRun(PtB);
      waitRy(400, edges, seen);
      checks++; if (CT !== CtB) begin errors++; $display("FAIL b2b_ct1: got %h want %h", CT, CtB); end
      @(negedge Clk);
      En = 1'b0;
      @(posedge Clk); #1;
      checks++; if (Ry !== 1'b0) begin errors++; $display("FAIL b2b_fall: Ry got %b want 0", Ry); end
      @(negedge Clk);
      setKey(KeyA);
      PT = PtA;
      En = 1'b1;
      @(posedge Clk); #1;
      checks++; if (CT !== CtB) begin errors++; $display("FAIL b2b_ctkeep: got %h want %h", CT, CtB); end
      edges = 1;
      seen = 1'b0;
      while (!seen && edges < 400) begin
         @(posedge Clk); edges++; #1;
         if (Ry) seen = 1'b1;
      end
      checks++; if (edges !== 81) begin errors++; $display("FAIL b2b_latency: got %0d edges want 81", edges); end
      checks++; if (CT !== CtA) begin errors++; $display("FAIL b2b_ct2: got %h want %h", CT, CtA); end
      @(negedge Clk);
      En = 1'b0;
      @(posedge Clk);
   endtask

`ifdef AES_ENC_TIMEOUT_EN
   task automatic test_timeout();
      int n;
      setKey(KeyA);
      readyDelay = 0;
      stallShift = 1'b1;
      startRun(PtB);
      n = 0;
      do begin @(negedge Clk); n++; end while (!ShiftEn && n < 20);
      checks++; if (ShiftEn !== 1'b1) begin errors++; $display("FAIL to_find: ShiftEn got %b want 1", ShiftEn); end
      n = 0;
      do begin @(posedge Clk); n++; #1; end while (!Err && n < 100);
      checks++; if (n !== 16) begin errors++; $display("FAIL to_cycles: Err after %0d edges want 16", n); end
      checks++;
      if (Err !== 1'b1 || enVec !== 4'd0 || Ry !== 1'b0 || CT !== CtA) begin
         errors++;
         $display("FAIL to_state: got err=%b en=%b ry=%b ct=%h want err=1 en=0 ry=0 ct=%h", Err,
                  enVec, Ry, CT, CtA);
      end
      @(negedge Clk);
      En = 1'b0;
      stallShift = 1'b0;
      @(posedge Clk); #1;
      checks++; if (Err !== 1'b0 || enVec !== 4'd0 || Text !== 128'h0) begin errors++; $display("FAIL to_exit: got err=%b en=%b text=%h want 0", Err, enVec, Text); end
   endtask
`endif

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   initial begin
      buildSbox();
      setKey(KeyA);
      test_reset();
      test_known_answer();
      test_sequence();
      test_stretched();
      test_spurious();
      test_reset_midrun();
      test_back_to_back();
`ifdef AES_ENC_TIMEOUT_EN
      test_timeout();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
